// File: rtl/regfile_wb_sched.sv
// Writeback scheduler and hazard scoreboard for a 2-read/1-write register file.
// Round-robin arbitrates ALU/LSU writebacks onto the write port and stalls issue on RAW/WAW.
module regfile_wb_sched #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rs1,
    input  logic [AW-1:0]   issue_rs2,
    input  logic [AW-1:0]   issue_rd,
    input  logic            issue_wr,
    output logic            issue_stall,
    input  logic            alu_wb_valid,
    input  logic [AW-1:0]   alu_wb_rd,
    input  logic [XLEN-1:0] alu_wb_data,
    output logic            alu_wb_ready,
    input  logic            lsu_wb_valid,
    input  logic [AW-1:0]   lsu_wb_rd,
    input  logic [XLEN-1:0] lsu_wb_data,
    output logic            lsu_wb_ready,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [NREG-1:0] pending,
    output logic            wb_err
);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_t;

    logic [NREG-1:0] r_pending;
    logic            r_rf_we;
    logic [AW-1:0]   r_rf_waddr;
    logic [XLEN-1:0] r_rf_wdata;
    logic            r_wb_err;
    src_t            r_last_grant;

    logic            w_haz;
    logic            w_alu_gnt;
    logic            w_lsu_gnt;
    logic            w_hs;
    logic            w_wb_nz;
    logic [AW-1:0]   w_wb_rd;
    logic [XLEN-1:0] w_wb_data;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;

    always_comb begin
        w_haz = (r_pending[issue_rs1] && (issue_rs1 != '0))
              || (r_pending[issue_rs2] && (issue_rs2 != '0))
              || (issue_wr && r_pending[issue_rd] && (issue_rd != '0));

        // A source wins outright when alone, otherwise whichever did not win last
        w_alu_gnt = !reset && alu_wb_valid && (!lsu_wb_valid || (r_last_grant == SRC_LSU));
        w_lsu_gnt = !reset && lsu_wb_valid && (!alu_wb_valid || (r_last_grant == SRC_ALU));
        w_hs      = w_alu_gnt || w_lsu_gnt;
        w_wb_rd   = w_alu_gnt ? alu_wb_rd   : lsu_wb_rd;
        w_wb_data = w_alu_gnt ? alu_wb_data : lsu_wb_data;
        w_wb_nz   = w_hs && (w_wb_rd != '0);

        w_set = '0;
        if (issue_valid && !w_haz && issue_wr && (issue_rd != '0))
            w_set[issue_rd] = 1'b1;
        w_clr = '0;
        if (w_wb_nz)
            w_clr[w_wb_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending    <= '0;
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= '0;
            r_rf_wdata   <= '0;
            r_wb_err     <= 1'b0;
            r_last_grant <= SRC_LSU;
        end else begin
            // Issue can never set the bit being cleared: WAW stalls it
            r_pending <= (r_pending & ~w_clr) | w_set;
            r_rf_we   <= w_wb_nz;
            if (w_wb_nz) begin
                r_rf_waddr <= w_wb_rd;
                r_rf_wdata <= w_wb_data;
                if (!r_pending[w_wb_rd])
                    r_wb_err <= 1'b1;
            end
            if (w_hs)
                r_last_grant <= w_alu_gnt ? SRC_ALU : SRC_LSU;
        end
    end

    assign issue_stall  = issue_valid && w_haz;
    assign alu_wb_ready = w_alu_gnt;
    assign lsu_wb_ready = w_lsu_gnt;
    assign rf_we        = r_rf_we;
    assign rf_waddr     = r_rf_waddr;
    assign rf_wdata     = r_rf_wdata;
    assign pending      = r_pending;
    assign wb_err       = r_wb_err;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench for regfile_wb_sched: scenario tasks plus a write-port scoreboard
// that expects each accepted nonzero-rd writeback on the register file one cycle later.
module tb_regfile_wb_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rs1 = '0;
    logic [4:0]  issue_rs2 = '0;
    logic [4:0]  issue_rd = '0;
    logic        issue_wr = 1'b0;
    logic        issue_stall;
    logic        alu_wb_valid = 1'b0;
    logic [4:0]  alu_wb_rd = '0;
    logic [31:0] alu_wb_data = '0;
    logic        alu_wb_ready;
    logic        lsu_wb_valid = 1'b0;
    logic [4:0]  lsu_wb_rd = '0;
    logic [31:0] lsu_wb_data = '0;
    logic        lsu_wb_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pending;
    logic        wb_err;

    regfile_wb_sched #(.XLEN(32), .NREG(32), .AW(5)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_wr(issue_wr), .issue_stall(issue_stall),
        .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
        .alu_wb_ready(alu_wb_ready),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
        .lsu_wb_ready(lsu_wb_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pending(pending), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        int          due;
    } wr_t;

    wr_t         sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    bit          mon_en = 1'b0;
    logic [31:0] m_pending = '0;
    logic        m_last = 1'b1;   // 1 = LSU granted last
    logic        m_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                if (rf_we !== 1'b1 || rf_waddr !== sb[0].a || rf_wdata !== sb[0].d)
                    $display("FAIL sb_write: got we=%b addr=%0d data=%h, want we=1 addr=%0d data=%h",
                             rf_we, rf_waddr, rf_wdata, sb[0].a, sb[0].d);
                else
                    n_pass++;
                void'(sb.pop_front());
            end else begin
                if (rf_we !== 1'b0)
                    $display("FAIL sb_idle: got we=%b addr=%0d, want we=0 at cycle %0d",
                             rf_we, rf_waddr, cyc);
                else
                    n_pass++;
            end
        end
    end

    // Advances the reference model over the coming edge, queues the expected write, then
    // waits for the following negedge.
    task automatic cycle_end();
        logic        ag, lg, haz;
        logic [4:0]  wrd;
        logic [31:0] wd;
        if (reset) begin
            m_pending = '0;
            m_last    = 1'b1;
            m_err     = 1'b0;
        end else begin
            ag  = alu_wb_valid && (!lsu_wb_valid || m_last);
            lg  = lsu_wb_valid && (!alu_wb_valid || !m_last);
            haz = (m_pending[issue_rs1] && issue_rs1 != 0) || (m_pending[issue_rs2] && issue_rs2 != 0)
                  || (issue_wr && m_pending[issue_rd] && issue_rd != 0);
            if (ag || lg) begin
                wrd = ag ? alu_wb_rd : lsu_wb_rd;
                wd  = ag ? alu_wb_data : lsu_wb_data;
                if (wrd != 0) begin
                    if (!m_pending[wrd]) m_err = 1'b1;
                    m_pending[wrd] = 1'b0;
                    sb.push_back('{a: wrd, d: wd, due: cyc + 1});
                end
                m_last = lg;
            end
            if (issue_valid && !haz && issue_wr && issue_rd != 0)
                m_pending[issue_rd] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        alu_wb_valid = 1'b1;
        lsu_wb_valid = 1'b1;
        alu_wb_rd    = 5'd1;
        lsu_wb_rd    = 5'd2;
        #1;
        n_checks++;
        if (alu_wb_ready !== 1'b0 || lsu_wb_ready !== 1'b0)
            $display("FAIL reset_ready: got alu=%b lsu=%b, want 0 0", alu_wb_ready, lsu_wb_ready);
        else n_pass++;
        cycle_end();
        cycle_end();
        n_checks++;
        if (pending !== 32'h0 || rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h0 || wb_err !== 1'b0)
            $display("FAIL reset_state: got pend=%h we=%b addr=%0d data=%h err=%b, want all 0",
                     pending, rf_we, rf_waddr, rf_wdata, wb_err);
        else n_pass++;
        reset        = 1'b0;
        alu_wb_valid = 1'b0;
        lsu_wb_valid = 1'b0;
        mon_en       = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [4:0] alu_rds [3];
        logic [4:0] lsu_rds [2];
        logic       exp_alu [4];
        int         ai, li;
        alu_rds = '{5'd10, 5'd12, 5'd14};
        lsu_rds = '{5'd11, 5'd13};
        exp_alu = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int r = 10; r <= 14; r++) begin
            issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'(r);
            issue_rs1 = 5'd0; issue_rs2 = 5'd0;
            #1;
            n_checks++;
            if (issue_stall !== 1'b0)
                $display("FAIL rr_issue: rd=%0d got stall=%b, want 0", r, issue_stall);
            else n_pass++;
            cycle_end();
        end
        issue_valid = 1'b0;
        ai = 0; li = 0;
        for (int i = 0; i < 4; i++) begin
            alu_wb_valid = 1'b1; alu_wb_rd = alu_rds[ai]; alu_wb_data = 32'hA000_0000 + 32'(i);
            lsu_wb_valid = 1'b1; lsu_wb_rd = lsu_rds[li]; lsu_wb_data = 32'hB000_0000 + 32'(i);
            #1;
            n_checks++;
            if (alu_wb_ready !== exp_alu[i] || lsu_wb_ready !== !exp_alu[i])
                $display("FAIL rr_grant%0d: got alu=%b lsu=%b, want alu=%b lsu=%b",
                         i, alu_wb_ready, lsu_wb_ready, exp_alu[i], !exp_alu[i]);
            else n_pass++;
            if (exp_alu[i]) ai++; else li++;
            cycle_end();
        end
        lsu_wb_valid = 1'b0;
        alu_wb_rd = alu_rds[ai]; alu_wb_data = 32'hA0A0_0014;
        #1;
        n_checks++;
        if (alu_wb_ready !== 1'b1)
            $display("FAIL rr_alone: got alu_ready=%b, want 1", alu_wb_ready);
        else n_pass++;
        cycle_end();
        alu_wb_valid = 1'b0;
        #1;
        n_checks++;
        if (pending !== 32'h0 || wb_err !== 1'b0)
            $display("FAIL rr_drain: got pend=%h err=%b, want 0 0", pending, wb_err);
        else n_pass++;
    endtask

    task automatic test_raw_stall();
        issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd5; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
        cycle_end();
        issue_rs1 = 5'd5; issue_rd = 5'd6;
        #1;
        n_checks++;
        if (pending !== 32'h20 || issue_stall !== 1'b1)
            $display("FAIL raw_set: got pend=%h stall=%b, want 00000020 1", pending, issue_stall);
        else n_pass++;
        cycle_end();
        #1;
        n_checks++;
        if (issue_stall !== 1'b1)
            $display("FAIL raw_hold: got stall=%b, want 1", issue_stall);
        else n_pass++;
        lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd5; lsu_wb_data = 32'h0000_0055;
        #1;
        n_checks++;
        if (lsu_wb_ready !== 1'b1 || issue_stall !== 1'b1)
            $display("FAIL raw_nobypass: got ready=%b stall=%b, want 1 1", lsu_wb_ready, issue_stall);
        else n_pass++;
        cycle_end();
        lsu_wb_valid = 1'b0;
        #1;
        n_checks++;
        if (issue_stall !== 1'b0 || pending !== 32'h0)
            $display("FAIL raw_release: got stall=%b pend=%h, want 0 00000000", issue_stall, pending);
        else n_pass++;
        cycle_end();
        issue_valid = 1'b1; issue_rs1 = 5'd0; issue_rd = 5'd6;
        #1;
        n_checks++;
        if (issue_stall !== 1'b1 || pending !== m_pending)
            $display("FAIL waw_stall: got stall=%b pend=%h, want 1 %h", issue_stall, pending, m_pending);
        else n_pass++;
        issue_valid = 1'b0;
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd6; alu_wb_data = 32'h6666_6666;
        cycle_end();
        alu_wb_valid = 1'b0;
    endtask

    task automatic test_lsu_data();
        issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd7;
        cycle_end();
        issue_valid = 1'b0;
        lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd7; lsu_wb_data = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (lsu_wb_ready !== 1'b1)
            $display("FAIL lsu_ready: got %b, want 1", lsu_wb_ready);
        else n_pass++;
        cycle_end();
        lsu_wb_valid = 1'b0;
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hDEAD_BEEF || pending[7] !== 1'b0)
            $display("FAIL lsu_write: got we=%b addr=%0d data=%h p7=%b, want 1 7 deadbeef 0",
                     rf_we, rf_waddr, rf_wdata, pending[7]);
        else n_pass++;
        cycle_end();
        n_checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd7 || rf_wdata !== 32'hDEAD_BEEF)
            $display("FAIL lsu_hold: got we=%b addr=%0d data=%h, want 0 7 deadbeef",
                     rf_we, rf_waddr, rf_wdata);
        else n_pass++;
    endtask

    task automatic test_rd0();
        issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd2;
        cycle_end();
        issue_valid = 1'b0;
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd0; alu_wb_data = 32'h0000_1234;
        #1;
        n_checks++;
        if (alu_wb_ready !== 1'b1)
            $display("FAIL rd0_ready: got %b, want 1", alu_wb_ready);
        else n_pass++;
        cycle_end();
        alu_wb_valid = 1'b0;
        #1;
        n_checks++;
        if (rf_we !== 1'b0 || pending !== 32'h4 || wb_err !== 1'b0)
            $display("FAIL rd0_effect: got we=%b pend=%h err=%b, want 0 00000004 0", rf_we, pending, wb_err);
        else n_pass++;
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd2; alu_wb_data = 32'h2222_2222;
        cycle_end();
        alu_wb_valid = 1'b0;
    endtask

    task automatic test_wb_err();
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd9; alu_wb_data = 32'h0000_0999;
        #1;
        n_checks++;
        if (alu_wb_ready !== 1'b1 || wb_err !== 1'b0)
            $display("FAIL err_pre: got ready=%b err=%b, want 1 0", alu_wb_ready, wb_err);
        else n_pass++;
        cycle_end();
        alu_wb_valid = 1'b0;
        #1;
        n_checks++;
        if (wb_err !== 1'b1 || wb_err !== m_err)
            $display("FAIL err_set: got err=%b, want 1", wb_err);
        else n_pass++;
        repeat (3) cycle_end();
        n_checks++;
        if (wb_err !== 1'b1)
            $display("FAIL err_sticky: got err=%b, want 1", wb_err);
        else n_pass++;
        reset = 1'b1;
        cycle_end();
        reset = 1'b0;
        #1;
        n_checks++;
        if (wb_err !== 1'b0)
            $display("FAIL err_clear: got err=%b, want 0", wb_err);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd3;
        cycle_end();
        issue_rd = 5'd4;
        cycle_end();
        issue_valid = 1'b0;
        #1;
        n_checks++;
        if (pending !== 32'h18)
            $display("FAIL mid_pend: got %h, want 00000018", pending);
        else n_pass++;
        reset = 1'b1;
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd3; alu_wb_data = 32'h3333_3333;
        #1;
        n_checks++;
        if (alu_wb_ready !== 1'b0 || lsu_wb_ready !== 1'b0)
            $display("FAIL mid_ready: got alu=%b lsu=%b, want 0 0", alu_wb_ready, lsu_wb_ready);
        else n_pass++;
        cycle_end();
        #1;
        n_checks++;
        if (pending !== 32'h0 || rf_we !== 1'b0)
            $display("FAIL mid_state: got pend=%h we=%b, want 0 0", pending, rf_we);
        else n_pass++;
        reset = 1'b0;
        alu_wb_valid = 1'b0;
        cycle_end();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_raw_stall();
        test_lsu_data();
        test_rd0();
        test_wb_err();
        test_reset_mid();
        cycle_end();
        n_checks++;
        if (sb.size() != 0)
            $display("FAIL sb_drain: %0d writes never seen, want 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
